dispatch_buffer: RTL and testbench

Parametrised per-class dispatch buffer between the renaming frontend and the execution units of the out-of-order 6502 core. It replaces the fixed three-queue, always-ready wiring with CHANNELS independent FIFOs (default ALU, MEM, TERM) of DEPTH entries each. Each channel has a registered, full-based backpressure signal toward the frontend, so that signal has no combinational dependence on the execution unit's ready. A global flush discards all buffered ops on mispredict or exception.

---
 rtl/dispatch_buffer_pkg.sv | 16 +
 rtl/dispatch_fifo.sv | 62 ++++++
 rtl/dispatch_buffer.sv | 40 ++++
 tb/tb_dispatch_buffer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dispatch_buffer_pkg.sv
// dispatch_buffer_pkg: shared renamed-op width, channel indices and default sizing.
// Optional feature macro used by the buffer: DISPATCH_BYPASS_EN.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 16
`endif

package dispatch_buffer_pkg;
    typedef enum logic [1:0] {
        CH_ALU  = 2'd0,
        CH_MEM  = 2'd1,
        CH_TERM = 2'd2
    } ch_e;

    localparam int DEFAULT_CHANNELS = 3;
    localparam int DEFAULT_DEPTH    = 4;
endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: one channel's circular op FIFO with registered full-based backpressure.
// DISPATCH_BYPASS_EN lets an empty FIFO forward its input straight to the output.
module dispatch_fifo
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int OP_W  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [OP_W-1:0]  in_op_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [OP_W-1:0]  out_op_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] count_o
);
    logic [OP_W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty, byp, push, pop;

    always_comb begin
        empty = cnt_q == '0;
`ifdef DISPATCH_BYPASS_EN
        byp = empty && !flush_i && in_valid_i;
`else
        byp = 1'b0;
`endif
        in_ready_o  = (cnt_q != CNT_W'(DEPTH)) && !flush_i;
        out_valid_o = (!empty && !flush_i) || byp;
        out_op_o    = byp ? in_op_i : mem_q[rd_q];
        // a bypassed op taken this cycle is never written
        push  = in_valid_i && in_ready_o && !(byp && out_ready_i);
        pop   = out_valid_o && out_ready_i && !byp;
        rd_d  = flush_i ? '0 : rd_q + PW'(pop);
        wr_d  = flush_i ? '0 : wr_q + PW'(push);
        cnt_d = flush_i ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= in_op_i;
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: CHANNELS independent dispatch FIFOs between rename and the execution units.
// Build with DISPATCH_BYPASS_EN for zero-latency forwarding through empty channels.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 16
`endif

module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int OP_W     = `RENAMED_OP_SZ,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [CHANNELS*OP_W-1:0]  in_op_i,
    input  logic [CHANNELS-1:0]       in_valid_i,
    output logic [CHANNELS-1:0]       in_ready_o,
    output logic [CHANNELS*OP_W-1:0]  out_op_o,
    output logic [CHANNELS-1:0]       out_valid_o,
    input  logic [CHANNELS-1:0]       out_ready_i,
    output logic [CHANNELS*CNT_W-1:0] count_o
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        dispatch_fifo #(.DEPTH(DEPTH), .OP_W(OP_W)) u_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .flush_i     (flush_i),
            .in_op_i     (in_op_i[c*OP_W +: OP_W]),
            .in_valid_i  (in_valid_i[c]),
            .in_ready_o  (in_ready_o[c]),
            .out_op_o    (out_op_o[c*OP_W +: OP_W]),
            .out_valid_o (out_valid_o[c]),
            .out_ready_i (out_ready_i[c]),
            .count_o     (count_o[c*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: table-driven directed checks of the 3x4 dispatch buffer with 8-bit ops.
module tb_dispatch_buffer;
    localparam int CH = 3, D = 4, W = 8, CW = 3;

    logic            clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [CH-1:0]   iv = '0, ordy = '0, ir, ov;
    logic [CH*W-1:0] iop = '0, oop;
    logic [CH*CW-1:0] cnt;
    int checks = 0, errors = 0;

    dispatch_buffer #(.CHANNELS(CH), .DEPTH(D), .OP_W(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_op_i(iop), .in_valid_i(iv), .in_ready_o(ir),
        .out_op_o(oop), .out_valid_o(ov), .out_ready_i(ordy),
        .count_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [2:0]  iv, ordy, eov, eir;
        logic [23:0] iop, eop;
        logic [8:0]  ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [8:0] c3(input int a2, input int a1, input int a0);
        return {3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [23:0] o3(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
        return {b2, b1, b0};
    endfunction

    function automatic vec_t mk(input logic fl, input logic [2:0] v, input logic [23:0] op,
                                input logic [2:0] r, input logic [2:0] eov, input logic [2:0] eir,
                                input logic [8:0] ecnt, input logic [23:0] eop);
        vec_t t;
        t.fl = fl; t.iv = v; t.iop = op; t.ordy = r;
        t.eov = eov; t.eir = eir; t.ecnt = ecnt; t.eop = eop;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input int idx);
        vec_t e;
        e = t;
        @(negedge clk);
        flush = t.fl; iv = t.iv; iop = t.iop; ordy = t.ordy;
`ifdef DISPATCH_BYPASS_EN
        for (int c = 0; c < CH; c++)
            if (!t.fl && t.iv[c] && t.ecnt[c*CW +: CW] == 0) begin
                e.eov[c] = 1'b1;
                e.eop[c*W +: W] = t.iop[c*W +: W];
            end
`endif
        #2;
        chk($sformatf("v%0d_out_valid", idx), 32'(ov), 32'(e.eov));
        chk($sformatf("v%0d_in_ready", idx), 32'(ir), 32'(e.eir));
        chk($sformatf("v%0d_count", idx), 32'(cnt), 32'(e.ecnt));
        for (int c = 0; c < CH; c++)
            if (e.eov[c]) chk($sformatf("v%0d_out_op%0d", idx, c), 32'(oop[c*W +: W]), 32'(e.eop[c*W +: W]));
    endtask

    initial begin
        // fill channel 1, attempt a push while full, then drain in order
        tbl.push_back(mk(0, 3'b010, o3(0, 8'h11, 0), 3'b000, 3'b000, 3'b111, c3(0, 0, 0), 0));
        tbl.push_back(mk(0, 3'b010, o3(0, 8'h12, 0), 3'b000, 3'b010, 3'b111, c3(0, 1, 0), o3(0, 8'h11, 0)));
        tbl.push_back(mk(0, 3'b010, o3(0, 8'h13, 0), 3'b000, 3'b010, 3'b111, c3(0, 2, 0), o3(0, 8'h11, 0)));
        tbl.push_back(mk(0, 3'b010, o3(0, 8'h14, 0), 3'b000, 3'b010, 3'b111, c3(0, 3, 0), o3(0, 8'h11, 0)));
        tbl.push_back(mk(0, 3'b010, o3(0, 8'h99, 0), 3'b000, 3'b010, 3'b101, c3(0, 4, 0), o3(0, 8'h11, 0)));
        tbl.push_back(mk(0, 3'b000, 0, 3'b010, 3'b010, 3'b101, c3(0, 4, 0), o3(0, 8'h11, 0)));
        tbl.push_back(mk(0, 3'b000, 0, 3'b010, 3'b010, 3'b111, c3(0, 3, 0), o3(0, 8'h12, 0)));
        tbl.push_back(mk(0, 3'b000, 0, 3'b010, 3'b010, 3'b111, c3(0, 2, 0), o3(0, 8'h13, 0)));
        tbl.push_back(mk(0, 3'b000, 0, 3'b010, 3'b010, 3'b111, c3(0, 1, 0), o3(0, 8'h14, 0)));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 3'b111, c3(0, 0, 0), 0));
        // channel 0: one op primed, then 10 push/pop pairs across the pointer wrap
        tbl.push_back(mk(0, 3'b001, o3(0, 0, 8'h20), 3'b000, 3'b000, 3'b111, c3(0, 0, 0), 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 3'b001, o3(0, 0, 8'(8'h21 + i)), 3'b001, 3'b001, 3'b111,
                             c3(0, 0, 1), o3(0, 0, 8'(8'h20 + i))));
        tbl.push_back(mk(0, 3'b000, 0, 3'b001, 3'b001, 3'b111, c3(0, 0, 1), o3(0, 0, 8'h2A)));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 3'b111, c3(0, 0, 0), 0));
        // channel 2 full, push and pop together: only the pop happens
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 3'b100, o3(8'(8'h31 + i), 0, 0), 3'b000, (i == 0) ? 3'b000 : 3'b100,
                             3'b111, c3(i, 0, 0), o3(8'h31, 0, 0)));
        tbl.push_back(mk(0, 3'b100, o3(8'h35, 0, 0), 3'b100, 3'b100, 3'b011, c3(4, 0, 0), o3(8'h31, 0, 0)));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b100, 3'b111, c3(3, 0, 0), o3(8'h32, 0, 0)));
        // build occupancy {ch0=2, ch1=4, ch2=1}, then flush with a push and pop presented
        tbl.push_back(mk(0, 3'b011, o3(0, 8'h51, 8'h41), 3'b100, 3'b100, 3'b111, c3(3, 0, 0), o3(8'h32, 0, 0)));
        tbl.push_back(mk(0, 3'b011, o3(0, 8'h52, 8'h42), 3'b100, 3'b111, 3'b111, c3(2, 1, 1), o3(8'h33, 8'h51, 8'h41)));
        tbl.push_back(mk(0, 3'b010, o3(0, 8'h53, 0), 3'b000, 3'b111, 3'b111, c3(1, 2, 2), o3(8'h34, 8'h51, 8'h41)));
        tbl.push_back(mk(0, 3'b010, o3(0, 8'h54, 0), 3'b000, 3'b111, 3'b111, c3(1, 3, 2), o3(8'h34, 8'h51, 8'h41)));
        tbl.push_back(mk(1, 3'b111, o3(8'h63, 8'h62, 8'h61), 3'b111, 3'b000, 3'b000, c3(1, 4, 2), 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b111, 3'b000, 3'b111, c3(0, 0, 0), 0));

        #12;
        chk("reset_count", 32'(cnt), 0);
        chk("reset_out_valid", 32'(ov), 0);
        chk("reset_in_ready", 32'(ir), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

        // empty channel 0 with op offered and taken in the same cycle
        @(negedge clk);
        flush = 0; iv = 3'b001; iop = o3(0, 0, 8'hA5); ordy = 3'b001;
        #2;
`ifdef DISPATCH_BYPASS_EN
        chk("byp_out_valid", 32'(ov[0]), 1);
        chk("byp_out_op", 32'(oop[7:0]), 32'hA5);
        @(negedge clk);
        iv = 0; iop = 0;
        #2;
        chk("byp_count_after", 32'(cnt), 0);
        chk("byp_out_valid_after", 32'(ov), 0);
`else
        chk("nobyp_out_valid", 32'(ov[0]), 0);
        @(negedge clk);
        iv = 0; iop = 0;
        #2;
        chk("nobyp_out_valid_next", 32'(ov[0]), 1);
        chk("nobyp_out_op_next", 32'(oop[7:0]), 32'hA5);
        chk("nobyp_count_next", 32'(cnt), 1);
        @(negedge clk);
        ordy = 0;
        #2;
        chk("nobyp_count_drained", 32'(cnt), 0);
`endif

        // asynchronous reset with three ops buffered in channel 0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv = 3'b001; iop = o3(0, 0, 8'(8'h71 + i)); ordy = 0;
        end
        @(negedge clk);
        iv = 0; iop = 0;
        #1;
        chk("pre_rst_count", 32'(cnt), 32'(c3(0, 0, 3)));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(cnt), 0);
        chk("async_rst_out_valid", 32'(ov), 0);
        chk("async_rst_in_ready", 32'(ir), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("post_rst_count", 32'(cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
